// File: rtl/move_replay_driver.sv
// Records live one-pulsed direction presses and replays them as spaced move pulses.
// Live presses pass through to the game while idle or recording; replay blocks them.
module move_replay_driver #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 48
) (
  input  logic          clk_20,
  input  logic          rst,
  input  logic          rec_en,
  input  logic          play,
  input  logic          clear,
  input  logic          in_right,
  input  logic          in_left,
  input  logic          in_up,
  input  logic          in_down,
  output logic          out_right,
  output logic          out_left,
  output logic          out_up,
  output logic          out_down,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic          busy,
  output logic          done
);

  localparam int GW = $clog2(GAP + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY, S_GAP} state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW:0]   rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    moves;

  logic          press;
  logic [1:0]    press_code;
  logic [1:0]    rd_code;
  logic          at_full;
  logic          wr_en;

  // Move code 0..3 to the {down, up, left, right} pulse vector.
  function automatic logic [3:0] onehot(input logic [1:0] code);
    case (code)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  endfunction

  // Priority encode simultaneous presses and decide whether this edge writes the buffer.
  always_comb begin
    press      = in_right | in_left | in_up | in_down;
    press_code = 2'd3;
    if (in_right) begin
      press_code = 2'd0;
    end else if (in_left) begin
      press_code = 2'd1;
    end else if (in_up) begin
      press_code = 2'd2;
    end else begin
      press_code = 2'd3;
    end
    at_full = (count == DEPTH_C);
    wr_en   = (state == S_RECORD) && press && !clear && !at_full;
    rd_code = mem[rd_ptr[AW-1:0]];
  end

  // Move buffer; contents are left alone by reset and clear.
  always_ff @(posedge clk_20) begin
    if (wr_en) begin
      mem[count[AW-1:0]] <= press_code;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_ptr   <= '0;
      gap_cnt  <= '0;
      moves    <= 4'b0000;
    end else begin
      done  <= 1'b0;
      moves <= 4'b0000;
      if (clear) begin
        state    <= S_IDLE;
        count    <= '0;
        full     <= 1'b0;
        overflow <= 1'b0;
        busy     <= 1'b0;
        rd_ptr   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (press) begin
              moves <= onehot(press_code);
            end
            if (rec_en) begin
              state <= S_RECORD;
            end else if (play && (count != '0)) begin
              state  <= S_PLAY;
              rd_ptr <= '0;
              busy   <= 1'b1;
            end
          end
          S_RECORD: begin
            if (press) begin
              moves <= onehot(press_code);
              if (at_full) begin
                overflow <= 1'b1;
              end else begin
                count <= count + ONE_C;
                full  <= ((count + ONE_C) == DEPTH_C);
              end
            end
            if (!rec_en) begin
              state <= S_IDLE;
            end
          end
          // Running past the last entry lands here once more to finish in step with GAP.
          S_PLAY: begin
            if (rd_ptr < count) begin
              moves   <= onehot(rd_code);
              gap_cnt <= GW'(GAP - 1);
              state   <= S_GAP;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_GAP: begin
            if (gap_cnt <= GW'(1)) begin
              rd_ptr <= rd_ptr + ONE_C;
              state  <= S_PLAY;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign out_right = moves[0];
  assign out_left  = moves[1];
  assign out_up    = moves[2];
  assign out_down  = moves[3];

endmodule

// File: tb/tb_move_replay_driver.sv
// Scoreboard bench for move_replay_driver: a queue-based model predicts pulse
// events and busy; a negedge monitor pops and compares whatever the DUT shows.
module tb_move_replay_driver;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 4;

  logic clk_20 = 1'b0;
  logic rst = 1'b1;
  logic rec_en = 1'b0, play = 1'b0, clear = 1'b0;
  logic in_right = 1'b0, in_left = 1'b0, in_up = 1'b0, in_down = 1'b0;
  logic out_right, out_left, out_up, out_down;
  logic [AW:0] count;
  logic full, overflow, busy, done;

  move_replay_driver #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
    .clk_20(clk_20), .rst(rst), .rec_en(rec_en), .play(play), .clear(clear),
    .in_right(in_right), .in_left(in_left), .in_up(in_up), .in_down(in_down),
    .out_right(out_right), .out_left(out_left), .out_up(out_up), .out_down(out_down),
    .count(count), .full(full), .overflow(overflow), .busy(busy), .done(done)
  );

  always #25 clk_20 = ~clk_20;

  int cyc = 0;
  always @(posedge clk_20) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Expected output event: edge number and code (0..3 move, 4 done).
  typedef struct {int cyc; int code;} ev_t;
  ev_t q[$];

  // Model: recorded codes, recording flag, sticky overflow, replay window.
  int rec_list[$];
  bit m_rec = 1'b0;
  bit m_ovf = 1'b0;
  int busy_start = 0;
  int busy_end = 0;

  function automatic int winner(input logic [3:0] m);
    if (m[0]) return 0;
    else if (m[1]) return 1;
    else if (m[2]) return 2;
    else return 3;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic purge_from(input int e);
    ev_t keep[$];
    foreach (q[i]) if (q[i].cyc < e) keep.push_back(q[i]);
    q = keep;
  endtask

  // One clock of stimulus; mask bits are {down, up, left, right}.
  task automatic drive(input logic [3:0] m, input logic pl, input logic cl);
    int e;
    int n;
    e = cyc + 1;
    {in_down, in_up, in_left, in_right} = m;
    play = pl;
    clear = cl;
    if (cl) begin
      purge_from(e);
      rec_list.delete();
      m_ovf = 1'b0;
      m_rec = 1'b0;
      if (busy_end > e) busy_end = e;
    end else if (e > busy_start && e <= busy_end) begin
      // replay owns the outputs; live presses, rec_en and play are ignored
    end else begin
      if (m != 4'b0000) q.push_back('{e, winner(m)});
      if (m_rec) begin
        if (m != 4'b0000) begin
          if (rec_list.size() < DEPTH) rec_list.push_back(winner(m));
          else m_ovf = 1'b1;
        end
        m_rec = rec_en;
      end else if (rec_en) begin
        m_rec = 1'b1;
      end else if (pl && rec_list.size() > 0) begin
        n = rec_list.size();
        busy_start = e;
        busy_end = e + 1 + n * GAP;
        for (int k = 0; k < n; k++) q.push_back('{e + 1 + k * GAP, rec_list[k]});
        q.push_back('{busy_end, 4});
      end
    end
    @(negedge clk_20);
    #2;
    {in_down, in_up, in_left, in_right} = 4'b0000;
    play = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic record_n(input int n);
    rec_en = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(4'($urandom_range(1, 15)), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) drive(4'b0000, 1'b0, 1'b0);
    end
    rec_en = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic check_store(input string tag);
    check({tag, "_count"}, int'(count), rec_list.size());
    check({tag, "_full"}, int'(full), (rec_list.size() == DEPTH) ? 1 : 0);
    check({tag, "_overflow"}, int'(overflow), int'(m_ovf));
  endtask

  // Runs until the modelled replay has finished; optional random live presses.
  task automatic wait_replay(input bit noisy);
    int g;
    g = 0;
    while (cyc <= busy_end && g < 1000) begin
      if (noisy && $urandom_range(0, 3) == 0) drive(4'($urandom_range(1, 15)), 1'b0, 1'b0);
      else drive(4'b0000, 1'b0, 1'b0);
      g++;
    end
    check("replay_bound", (g < 1000) ? 1 : 0, 1);
  endtask

  logic [4:0] mon_obs;
  logic [4:0] mon_exp;

  // Monitor: pops every event due this edge and compares pulses and busy.
  always @(negedge clk_20) begin
    if (!rst) begin
      mon_obs = {done, out_down, out_up, out_left, out_right};
      mon_exp = 5'b00000;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_event: code %0d due at cyc %0d never seen", q[0].code, q[0].cyc);
        void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].cyc == cyc) begin
        mon_exp[q[0].code] = 1'b1;
        void'(q.pop_front());
      end
      if (mon_obs != 5'b00000 || mon_exp != 5'b00000) begin
        tests++;
        if (mon_obs != mon_exp) begin
          fails++;
          $display("FAIL pulses: cyc %0d got %b expected %b ({done,down,up,left,right})",
                   cyc, mon_obs, mon_exp);
        end
      end
      tests++;
      if (busy != (cyc >= busy_start && cyc < busy_end)) begin
        fails++;
        $display("FAIL busy: cyc %0d got %0d expected %0d", cyc, busy,
                 (cyc >= busy_start && cyc < busy_end));
      end
    end
  end

  initial begin
    #30;
    check("rst_count", int'(count), 0);
    check("rst_outs", int'({done, busy, full, overflow, out_down, out_up, out_left, out_right}), 0);
    @(negedge clk_20);
    #2;
    rst = 1'b0;

    // Directed recording R,R,L,U with pass-through.
    rec_en = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    idle(2);
    drive(4'b0100, 1'b0, 1'b0);
    rec_en = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    check_store("rec4");

    // Replay with a live in_down at E0+3 that must not pass.
    drive(4'b0000, 1'b1, 1'b0);
    idle(2);
    drive(4'b1000, 1'b0, 1'b0);
    wait_replay(1'b0);
    check_store("after_play");

    // Repeat replay, then append a simultaneous right+up press.
    drive(4'b0000, 1'b1, 1'b0);
    wait_replay(1'b0);
    rec_en = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0101, 1'b0, 1'b0);
    rec_en = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    check_store("simul");
    drive(4'b0000, 1'b1, 1'b0);
    wait_replay(1'b0);

    // Overflow: 17 presses into a 16-entry buffer.
    drive(4'b0000, 1'b0, 1'b1);
    check_store("clear");
    record_n(17);
    check_store("ovf");
    drive(4'b0000, 1'b1, 1'b0);
    wait_replay(1'b0);

    // Async reset after the second replayed pulse.
    drive(4'b0000, 1'b0, 1'b1);
    record_n(3);
    drive(4'b0000, 1'b1, 1'b0);
    idle(GAP + 2);
    rst = 1'b1;
    q.delete();
    rec_list.delete();
    m_rec = 1'b0;
    m_ovf = 1'b0;
    busy_start = 0;
    busy_end = 0;
    #1;
    check("rst_mid_outs", int'({done, busy, out_down, out_up, out_left, out_right}), 0);
    check("rst_mid_count", int'(count), 0);
    @(negedge clk_20);
    #2;
    rst = 1'b0;
    drive(4'b0000, 1'b1, 1'b0);
    idle(20);

    // Clear and play together in IDLE.
    record_n(3);
    check_store("pre_clr_play");
    drive(4'b0000, 1'b1, 1'b1);
    check_store("clr_play");
    idle(10);

    // Clear in the middle of a gap.
    record_n(2);
    drive(4'b0000, 1'b1, 1'b0);
    idle(2);
    drive(4'b0000, 1'b0, 1'b1);
    idle(15);
    check_store("clr_gap");

    // Randomised record/replay rounds.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) drive(4'b0000, 1'b0, 1'b1);
      record_n($urandom_range(0, 12));
      check_store("rand_rec");
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
      drive(4'b0000, 1'b1, 1'b0);
      wait_replay(1'b1);
      check_store("rand_play");
    end

    idle(3);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
